stopwatch_controller: RTL

Control sequencer for the stopwatch datapath. It conditions the raw start/stop and lap/clear push-buttons and runs the run/pause/lap state machine. It generates the single-cycle count-enable tick, the clear pulse and the display-freeze level that drive the digit counter and display path. It sits between the board buttons and the timer, replacing the free-running divided clock with a count enable in the `i_clk` domain.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/button_conditioner.sv | 63 ++++++
 rtl/stopwatch_controller.sv | 111 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - state encoding and prescaler sizing for the stopwatch controller
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_e;

    function automatic int calc_tick_div(input int clk_freq, input int tick_freq);
        return clk_freq / tick_freq;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizer, debounce and press-edge detector for one button
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [1:0]    fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = i_button;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        // A button held through reset must be seen released before it can press.
        armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            level_d = sync2_q;
            press_d = sync2_q & armed_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            fill_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - run/pause/lap sequencer producing count-enable, clear and freeze
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ        = 100000000,
    parameter int TICK_FREQ       = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_startStop,
    input  logic       i_lapClear,
    output logic       o_tick,
    output logic       o_clear,
    output logic       o_freeze,
    output logic       o_running,
    output logic [1:0] o_state
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, TICK_FREQ);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic          ss_press, lc_press;
    logic          start_evt, lap_evt, counting;
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;
    logic          freeze_q, freeze_d;
    logic          running_q, running_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_btn (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_button (i_startStop),
        .o_press  (ss_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lc_btn (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_button (i_lapClear),
        .o_press  (lc_press)
    );

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        clear_d   = 1'b0;
        counting  = (state_q == ST_RUNNING) || (state_q == ST_LAP);
        // Tick and prescaler advance follow the pre-transition state.
        tick_d    = counting && (presc_q == PRESC_LAST);
        if (counting) begin
            presc_d = tick_d ? '0 : presc_q + PW'(1);
        end
        start_evt = ss_press;
        lap_evt   = lc_press & ~ss_press;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (start_evt)    state_d = ST_RUNNING;
                else if (lap_evt) clear_d = 1'b1;
            end
            ST_RUNNING: begin
                if (start_evt)    state_d = ST_PAUSED;
                else if (lap_evt) state_d = ST_LAP;
            end
            ST_PAUSED: begin
                if (start_evt) begin
                    state_d = ST_RUNNING;
                end else if (lap_evt) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end
            end
            ST_LAP: begin
                if (start_evt)    state_d = ST_PAUSED;
                else if (lap_evt) state_d = ST_RUNNING;
            end
            default: state_d = ST_IDLE;
        endcase
        freeze_d  = (state_d == ST_LAP);
        running_d = (state_d == ST_RUNNING) || (state_d == ST_LAP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            clear_q   <= 1'b0;
            freeze_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            clear_q   <= clear_d;
            freeze_q  <= freeze_d;
            running_q <= running_d;
        end
    end

    assign o_tick    = tick_q;
    assign o_clear   = clear_q;
    assign o_freeze  = freeze_q;
    assign o_running = running_q;
    assign o_state   = state_q;

endmodule
